// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// Time-multiplexes a DIGITS-nibble hex value onto one shared seven-segment
// decoder. A prescaler sets the slot length, a digit index walks the
// nibbles, and a shadow/pending pair defers new values to the frame
// boundary so a single frame never mixes old and new digits.
// Outputs are registered from the current index/display state, so they
// trail the index by one clock.
module hex_display_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Scan position
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Staged and displayed values
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;

  // Registered outputs
  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                frame_done_q, frame_done_d;

  // Decode helpers
  logic                tc;
  logic                wrap;
  logic                above_zero;
  logic [DIGITS-1:0]   lit;
  logic [3:0]          disp_nib [DIGITS];

  // Split the displayed value into per-digit nibbles for indexed selection.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign disp_nib[gi] = disp_q[4*gi +: 4];
  end

  // Leading-zero blanking: digit i>0 goes dark when it and every more
  // significant nibble are zero. Digit 0 always stays lit so a zero value
  // still shows "0".
  always_comb begin
    above_zero = 1'b1;
    lit        = '1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero && (disp_q[4*i +: 4] == 4'h0);
      if (BLANK_LZ && above_zero) begin
        lit[i] = 1'b0;
      end
    end
  end

  // Next-state: prescaler/index advance, shadow staging, frame commit and
  // the registered decoder drive.
  always_comb begin
    pre_d        = pre_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    nibble_d     = nibble_q;
    digit_en_d   = '1;
    tc           = enable && (pre_q == PRE_LAST);
    wrap         = tc && (idx_q == IDX_LAST);
    frame_done_d = wrap;

    if (enable) begin
      pre_d = tc ? '0 : pre_q + 1'b1;
    end
    // Explicit wrap keeps idx inside 0..DIGITS-1 for non-power-of-2 counts.
    if (tc) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // Commit happens only at the wrap; a load landing on the wrap itself
    // bypasses the shadow so it is not lost or delayed a frame.
    if (wrap) begin
      if (load) begin
        disp_d   = value;
        shadow_d = value;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    // While frozen the nibble holds and every digit is off.
    if (enable) begin
      nibble_d          = disp_nib[idx_q];
      digit_en_d[idx_q] = !lit[idx_q];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= 4'h0;
      digit_en_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble     = nibble_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner: two instances (blanking on / off)
// share stimulus; a cycle model pushes expected outputs before each clock
// and every task pops and compares after the following falling edge, plus
// hand-derived slot checks taken directly from the display patterns.
module tb_hex_display_scanner;

  localparam int DIGITS = 4;
  localparam int RD     = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] value  = 16'h0;

  logic [3:0]  nib_a, nib_b;
  logic [3:0]  en_a, en_b;
  logic        fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  // {nib_a, en_a, fd_a, nib_b, en_b, fd_b}
  logic [17:0] exp_q [$];
  logic [17:0] obs, expv;

  // Reference model state
  int          m_pre, m_idx;
  logic [15:0] m_shadow, m_disp;
  logic        m_pend, m_fd;
  logic [3:0]  m_nib, m_en_a, m_en_b;

  always #5 clk = ~clk;

  hex_display_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .nibble(nib_a), .digit_en(en_a), .frame_done(fd_a)
  );

  hex_display_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_LZ(1'b0)) u_nolz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .nibble(nib_b), .digit_en(en_b), .frame_done(fd_b)
  );

  // A digit above 0 is lit when anything at or above it is non-zero.
  function automatic logic digit_lit(input logic [15:0] v, input int i);
    return (i == 0) || ((v >> (4 * i)) != 16'h0);
  endfunction

  // Predict the outputs after the coming rising edge from current inputs.
  task automatic model_advance();
    logic       fd;
    logic [3:0] ea, eb;
    if (!rst_n) begin
      m_pre = 0; m_idx = 0; m_shadow = 16'h0; m_disp = 16'h0; m_pend = 1'b0;
      m_nib = 4'h0; m_en_a = 4'hF; m_en_b = 4'hF; m_fd = 1'b0;
    end else begin
      fd = enable && (m_pre == RD - 1) && (m_idx == DIGITS - 1);
      ea = 4'hF;
      eb = 4'hF;
      if (enable) begin
        m_nib     = m_disp[4*m_idx +: 4];
        eb[m_idx] = 1'b0;
        if (digit_lit(m_disp, m_idx)) ea[m_idx] = 1'b0;
      end
      if (fd) begin
        if (load) begin
          m_disp = value; m_shadow = value;
        end else if (m_pend) begin
          m_disp = m_shadow;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_shadow = value; m_pend = 1'b1;
      end
      if (enable) begin
        m_pre = m_pre + 1;
        if (m_pre == RD) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % DIGITS;
        end
      end
      m_fd = fd; m_en_a = ea; m_en_b = eb;
    end
    exp_q.push_back({m_nib, m_en_a, m_fd, m_nib, m_en_b, m_fd});
  endtask

  // One clock: push the prediction, then sample and pop after the fall.
  task automatic step();
    model_advance();
    @(negedge clk);
    obs = {nib_a, en_a, fd_a, nib_b, en_b, fd_b};
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else expv = 'x;
  endtask

  task automatic test_reset();
    int first_fd, second_fd;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = 16'h0;
    for (int j = 1; j <= 3; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_hold n=%0d got %b want %b", j, obs, expv); end
    end
    checks++;
    if (nib_a !== 4'h0 || en_a !== 4'hF || fd_a !== 1'b0 || en_b !== 4'hF) begin
      errors++;
      $display("FAIL reset_values got nib=%h en=%b fd=%b en_nolz=%b want nib=0 en=1111 fd=0 en_nolz=1111", nib_a, en_a, fd_a, en_b);
    end
    rst_n = 1'b1; enable = 1'b1;
    first_fd = -1; second_fd = -1;
    for (int j = 1; j <= 40; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_scan n=%0d got %b want %b", j, obs, expv); end
      if (fd_a === 1'b1) begin
        if (first_fd < 0) first_fd = j;
        else if (second_fd < 0) second_fd = j;
      end
    end
    checks++;
    if (first_fd != 16) begin errors++; $display("FAIL reset_first_frame got cycle %0d want 16", first_fd); end
    checks++;
    if (second_fd - first_fd != 16) begin errors++; $display("FAIL reset_frame_period got %0d want 16", second_fd - first_fd); end
  endtask

  task automatic test_full_value();
    logic [3:0] tn [4];
    logic [3:0] te [4];
    bit synced = 0;
    tn = '{4'hF, 4'h3, 4'hA, 4'h1};
    te = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int j = 0; j < 40 && !synced; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL full_sync n=%0d got %b want %b", j, obs, expv); end
      if (fd_a === 1'b1) synced = 1;
    end
    checks++;
    if (!synced) begin errors++; $display("FAIL full_sync frame_done got none want pulse within 40 cycles"); end
    for (int j = 0; j < 33; j++) begin
      load = (j == 0); value = 16'h1A3F;
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL full_value n=%0d got %b want %b", j + 1, obs, expv); end
      if (j + 1 >= 17 && j + 1 <= 32) begin
        checks++;
        if (nib_a !== tn[(j - 16) / 4] || en_a !== te[(j - 16) / 4]) begin
          errors++;
          $display("FAIL full_slot n=%0d got nib=%h en=%b want nib=%h en=%b", j + 1, nib_a, en_a, tn[(j - 16) / 4], te[(j - 16) / 4]);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_leading_zeros();
    logic [3:0] tn [4];
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    bit synced = 0;
    tn = '{4'h0, 4'h5, 4'h0, 4'h0};
    ta = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    tb = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int j = 0; j < 40 && !synced; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL lz_sync n=%0d got %b want %b", j, obs, expv); end
      if (fd_a === 1'b1) synced = 1;
    end
    checks++;
    if (!synced) begin errors++; $display("FAIL lz_sync frame_done got none want pulse within 40 cycles"); end
    for (int j = 0; j < 32; j++) begin
      load = (j == 0); value = 16'h0050;
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL leading_zeros n=%0d got %b want %b", j + 1, obs, expv); end
      if (j + 1 >= 17) begin
        checks++;
        if (nib_a !== tn[(j - 16) / 4] || en_a !== ta[(j - 16) / 4] || en_b !== tb[(j - 16) / 4]) begin
          errors++;
          $display("FAIL lz_slot n=%0d got nib=%h en=%b en_nolz=%b want nib=%h en=%b en_nolz=%b",
                   j + 1, nib_a, en_a, en_b, tn[(j - 16) / 4], ta[(j - 16) / 4], tb[(j - 16) / 4]);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_tear_free();
    bit synced = 0;
    int n;
    logic [3:0] wn, we;
    for (int j = 0; j < 40 && !synced; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL tear_sync n=%0d got %b want %b", j, obs, expv); end
      if (fd_a === 1'b1) synced = 1;
    end
    checks++;
    if (!synced) begin errors++; $display("FAIL tear_sync frame_done got none want pulse within 40 cycles"); end
    for (int j = 0; j < 40; j++) begin
      load = (j == 4) || (j == 20) || (j == 24);
      value = (j == 4) ? 16'h1234 : (j == 20) ? 16'h1111 : 16'h2222;
      step();
      n = j + 1;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL tear_free n=%0d got %b want %b", n, obs, expv); end
      if ((n >= 5 && n <= 8) || (n >= 17 && n <= 24) || (n >= 29 && n <= 40)) begin
        if (n <= 8)       begin wn = 4'h5; we = 4'b1101; end
        else if (n <= 20) begin wn = 4'h4; we = 4'b1110; end
        else if (n <= 24) begin wn = 4'h3; we = 4'b1101; end
        else if (n <= 32) begin wn = 4'h1; we = 4'b0111; end
        else if (n <= 36) begin wn = 4'h2; we = 4'b1110; end
        else              begin wn = 4'h2; we = 4'b1101; end
        checks++;
        if (nib_a !== wn || en_a !== we) begin
          errors++;
          $display("FAIL tear_slot n=%0d got nib=%h en=%b want nib=%h en=%b", n, nib_a, en_a, wn, we);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_on_wrap();
    logic [3:0] tn [4];
    logic [3:0] te [4];
    bit synced = 0;
    int n;
    tn = '{4'hF, 4'hE, 4'hE, 4'hB};
    te = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int j = 0; j < 40 && !synced; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL wrap_sync n=%0d got %b want %b", j, obs, expv); end
      if (fd_a === 1'b1) synced = 1;
    end
    checks++;
    if (!synced) begin errors++; $display("FAIL wrap_sync frame_done got none want pulse within 40 cycles"); end
    for (int j = 0; j < 48; j++) begin
      load  = (j == 2) || (j == 15);
      value = (j == 2) ? 16'h7777 : 16'hBEEF;
      step();
      n = j + 1;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL load_on_wrap n=%0d got %b want %b", n, obs, expv); end
      if (n >= 17 && (n - 17) % 4 == 0) begin
        checks++;
        if (nib_a !== tn[((n - 17) / 4) % 4] || en_a !== te[((n - 17) / 4) % 4]) begin
          errors++;
          $display("FAIL wrap_slot n=%0d got nib=%h en=%b want nib=%h en=%b",
                   n, nib_a, en_a, tn[((n - 17) / 4) % 4], te[((n - 17) / 4) % 4]);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_enable();
    bit synced = 0;
    int n;
    for (int j = 0; j < 40 && !synced; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL en_sync n=%0d got %b want %b", j, obs, expv); end
      if (fd_a === 1'b1) synced = 1;
    end
    checks++;
    if (!synced) begin errors++; $display("FAIL en_sync frame_done got none want pulse within 40 cycles"); end
    for (int j = 0; j < 31; j++) begin
      enable = !(j >= 8 && j < 18);
      load   = (j == 10); value = 16'h00C0;
      step();
      n = j + 1;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL enable n=%0d got %b want %b", n, obs, expv); end
      if (n >= 9 && n <= 18) begin
        checks++;
        if (en_a !== 4'hF || en_b !== 4'hF || nib_a !== 4'hE) begin
          errors++;
          $display("FAIL enable_frozen n=%0d got nib=%h en=%b en_nolz=%b want nib=e en=1111 en_nolz=1111", n, nib_a, en_a, en_b);
        end
      end
      if (n == 16 || n == 26) begin
        checks++;
        if (fd_a !== (n == 26)) begin errors++; $display("FAIL enable_frame n=%0d got fd=%b want %b", n, fd_a, n == 26); end
      end
      if (n == 19 || n == 27 || n == 31) begin
        checks++;
        if ((n == 19 && (nib_a !== 4'hE || en_a !== 4'b1011)) ||
            (n == 27 && (nib_a !== 4'h0 || en_a !== 4'b1110)) ||
            (n == 31 && (nib_a !== 4'hC || en_a !== 4'b1101))) begin
          errors++;
          $display("FAIL enable_resume n=%0d got nib=%h en=%b want %s", n, nib_a, en_a,
                   (n == 19) ? "nib=e en=1011" : (n == 27) ? "nib=0 en=1110" : "nib=c en=1101");
        end
      end
    end
    enable = 1'b1; load = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    load = 1'b1; value = 16'h9999;
    step();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL areset_pre got %b want %b", obs, expv); end
    load = 1'b0;
    checks++;
    if (nib_a !== 4'hC || en_a !== 4'b1101) begin
      errors++; $display("FAIL areset_before got nib=%h en=%b want nib=c en=1101", nib_a, en_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (nib_a !== 4'h0 || en_a !== 4'hF || fd_a !== 1'b0 || en_b !== 4'hF || nib_b !== 4'h0) begin
      errors++;
      $display("FAIL areset_async got nib=%h en=%b fd=%b en_nolz=%b want nib=0 en=1111 fd=0 en_nolz=1111", nib_a, en_a, fd_a, en_b);
    end
    for (int j = 0; j < 2; j++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL areset_hold got %b want %b", obs, expv); end
    end
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      n = j + 1;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL areset_scan n=%0d got %b want %b", n, obs, expv); end
      if (n == 16) begin
        checks++;
        if (fd_a !== 1'b1) begin errors++; $display("FAIL areset_frame got fd=%b want 1", fd_a); end
      end
      if (n >= 17) begin
        checks++;
        if (nib_a !== 4'h0 || en_a !== 4'b1110) begin
          errors++; $display("FAIL areset_discard n=%0d got nib=%h en=%b want nib=0 en=1110", n, nib_a, en_a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_value();
    test_leading_zeros();
    test_tear_free();
    test_load_on_wrap();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
